// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the DMEM arbiter slice: the Wishbone-side FSM state
// type, the requester IDs used by the last-grant register and the default
// Wishbone base address of the DMEM window.
// Ports: none (package).
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        WB_RESP = 1'b1
    } arb_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_WB   = 1'b1;

    localparam logic [31:0] DMEM_WB_BASE_DEFAULT = 32'h3000_0000;

endpackage

// File: rtl/dmem_rr_arb.sv
// ----------------------------------------------------------------------------
// dmem_rr_arb
// Two-way grant logic between the core data port and the Wishbone slave.
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin on collisions, the requester not granted last
//               wins; a last-grant register tracks every grant.
//   undefined : the core has fixed priority; purely combinational, so the
//               clock/reset ports are not present.
// Ports:
//   i_clk, i_rst_n  clock and async active-low reset (RR build only)
//   i_core_elig     core request is eligible this cycle
//   i_wb_elig       Wishbone request is eligible this cycle
//   o_gnt_core      core granted
//   o_gnt_wb        Wishbone granted
// ----------------------------------------------------------------------------
module dmem_rr_arb
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic i_clk,
    input  logic i_rst_n,
`endif
    input  logic i_core_elig,
    input  logic i_wb_elig,
    output logic o_gnt_core,
    output logic o_gnt_wb
);

    logic w_core_wins;

`ifdef DMEM_ARB_RR_EN
    logic r_last;

    // On a collision the core only wins if the Wishbone side was served last.
    always_comb begin
        w_core_wins = i_core_elig & (~i_wb_elig | (r_last == REQ_WB));
    end

    // Remember who was granted; reset leaves the Wishbone side as "last",
    // so the first collision after reset goes to the core.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= REQ_WB;
        end else if (o_gnt_core) begin
            r_last <= REQ_CORE;
        end else if (o_gnt_wb) begin
            r_last <= REQ_WB;
        end
    end
`else
    // Fixed priority: the core always wins a collision.
    always_comb begin
        w_core_wins = i_core_elig;
    end
`endif

    // At most one grant per cycle by construction.
    always_comb begin
        o_gnt_core = w_core_wins;
        o_gnt_wb   = i_wb_elig & ~w_core_wins;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port 32-bit SRAM between a core data port and a Wishbone
// classic slave window. Grants drive the SRAM port combinationally; read
// data comes back from the SRAM one cycle later.
// Configuration macro: DMEM_ARB_RR_EN (round-robin instead of core priority,
// handled inside dmem_rr_arb).
// Parameters: ADDR_W (SRAM word-address width), WB_BASE (window byte base).
// Ports:
//   wb_clk_i, wb_rstn_i                       clock, async active-low reset
//   core_req_i/we_i/be_i/addr_i/wdata_i       core request
//   core_gnt_o, core_rvalid_o, core_rdata_o   core grant and read return
//   wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i    Wishbone slave request
//   wbs_ack_o, wbs_dat_o                      Wishbone slave response
//   csb0_o, web0_o, wmask0_o, addr0_o, din0_o SRAM port (active-low enables)
//   dout0_i                                   SRAM read data (next cycle)
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] WB_BASE = DMEM_WB_BASE_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rstn_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [3:0]        core_be_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              csb0_o,
    output logic              web0_o,
    output logic [3:0]        wmask0_o,
    output logic [ADDR_W-1:0] addr0_o,
    output logic [31:0]       din0_o,
    input  logic [31:0]       dout0_i
);

    // Byte-offset bits covered by the window (4 bytes per word).
    localparam logic [31:0] WIN_MASK = (32'd4 << ADDR_W) - 32'd1;

    arb_state_t r_state;
    logic       r_wb_we;
    logic       r_core_rvalid;

    logic w_wb_elig;
    logic w_core_elig;
    logic w_gnt_core;
    logic w_gnt_wb;

    // Eligibility is gated by reset so that an asserted reset forces the idle
    // SRAM outputs and drops any grant within the same cycle.
    always_comb begin
        w_wb_elig   = wb_rstn_i & wbs_cyc_i & wbs_stb_i
                    & ((wbs_adr_i & ~WIN_MASK) == WB_BASE)
                    & (r_state == IDLE);
        w_core_elig = wb_rstn_i & core_req_i;
    end

    dmem_rr_arb u_arb (
`ifdef DMEM_ARB_RR_EN
        .i_clk       (wb_clk_i),
        .i_rst_n     (wb_rstn_i),
`endif
        .i_core_elig (w_core_elig),
        .i_wb_elig   (w_wb_elig),
        .o_gnt_core  (w_gnt_core),
        .o_gnt_wb    (w_gnt_wb)
    );

    // SRAM port mux: the granted requester drives the port directly, reads
    // always enable all byte lanes, and an idle port is held at a quiet
    // all-deasserted pattern.
    always_comb begin
        csb0_o   = 1'b1;
        web0_o   = 1'b1;
        wmask0_o = 4'h0;
        addr0_o  = '0;
        din0_o   = 32'h0;
        if (w_gnt_core) begin
            csb0_o   = 1'b0;
            web0_o   = ~core_we_i;
            wmask0_o = core_we_i ? core_be_i : 4'hF;
            addr0_o  = core_addr_i;
            din0_o   = core_wdata_i;
        end else if (w_gnt_wb) begin
            csb0_o   = 1'b0;
            web0_o   = ~wbs_we_i;
            wmask0_o = wbs_we_i ? wbs_sel_i : 4'hF;
            addr0_o  = wbs_adr_i[ADDR_W+1:2];
            din0_o   = wbs_dat_i;
        end
    end

    // Wishbone response FSM plus the core read-valid flag. WB_RESP lasts one
    // cycle and produces the ack whatever cyc/stb do in that cycle; reset
    // drops any access in flight so nothing is acknowledged afterwards.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state       <= IDLE;
            r_wb_we       <= 1'b0;
            r_core_rvalid <= 1'b0;
        end else begin
            r_core_rvalid <= w_gnt_core & ~core_we_i;
            case (r_state)
                IDLE: begin
                    if (w_gnt_wb) begin
                        r_state <= WB_RESP;
                        r_wb_we <= wbs_we_i;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Read data is only presented while the matching response is valid.
    always_comb begin
        core_gnt_o    = w_gnt_core;
        core_rvalid_o = r_core_rvalid;
        core_rdata_o  = r_core_rvalid ? dout0_i : 32'h0;
        wbs_ack_o     = (r_state == WB_RESP);
        wbs_dat_o     = ((r_state == WB_RESP) && !r_wb_we) ? dout0_i : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural 256x32 SRAM model.
// Expectations follow DMEM_ARB_RR_EN when the bench is built with it.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        logic        coreReq;
        logic        coreWe;
        logic [3:0]  coreBe;
        logic [7:0]  coreAddr;
        logic [31:0] coreWdata;
        logic        cyc;
        logic        stb;
        logic        wbWe;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        expCsb;
        logic        expWeb;
        logic [3:0]  expWmask;
        logic [7:0]  expAddr;
        logic [31:0] expDin;
        logic        expGnt;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        coreReq, coreWe, coreGnt, coreRvalid;
    logic [3:0]  coreBe;
    logic [7:0]  coreAddr;
    logic [31:0] coreWdata, coreRdata;
    logic        cyc, stb, wbWe, ack;
    logic [3:0]  sel;
    logic [31:0] adr, datIn, datOut;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [7:0]  sramAddr;
    logic [31:0] din;
    logic [31:0] dout = 32'h0;
    logic [31:0] mem [256];
    logic [31:0] merged;

    int nChecks = 0;
    int nFails  = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .WB_BASE(32'h3000_0000)) dut (
        .wb_clk_i      (clk),
        .wb_rstn_i     (rstn),
        .core_req_i    (coreReq),
        .core_we_i     (coreWe),
        .core_be_i     (coreBe),
        .core_addr_i   (coreAddr),
        .core_wdata_i  (coreWdata),
        .core_gnt_o    (coreGnt),
        .core_rvalid_o (coreRvalid),
        .core_rdata_o  (coreRdata),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (wbWe),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (datIn),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (datOut),
        .csb0_o        (csb),
        .web0_o        (web),
        .wmask0_o      (wmask),
        .addr0_o       (sramAddr),
        .din0_o        (din),
        .dout0_i       (dout)
    );

    // Behavioural SRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                merged = mem[sramAddr];
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) merged[8*b +: 8] = din[8*b +: 8];
                end
                mem[sramAddr] <= merged;
            end else begin
                dout <= mem[sramAddr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        coreReq = 1'b0; coreWe = 1'b0; coreBe = 4'h0; coreAddr = 8'h0; coreWdata = 32'h0;
        cyc = 1'b0; stb = 1'b0; wbWe = 1'b0; sel = 4'h0; adr = 32'h0; datIn = 32'h0;
    endtask

    task automatic applyStimulus(input vec_t v);
        coreReq = v.coreReq; coreWe = v.coreWe; coreBe = v.coreBe;
        coreAddr = v.coreAddr; coreWdata = v.coreWdata;
        cyc = v.cyc; stb = v.stb; wbWe = v.wbWe; sel = v.sel; adr = v.adr; datIn = v.dat;
    endtask

    task automatic driveSlot();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int badCycles;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        //                core: req we be   addr   wdata          wb: cyc stb we sel  adr            dat            exp: csb web mask addr   din            gnt
        vecs[0] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b1,1'b1,4'h0,8'h00,32'h0,        1'b0,"idle"};
        vecs[1] = '{1'b1,1'b1,4'h5,8'h10,32'hA5A5_5A5A,1'b0,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,4'h5,8'h10,32'hA5A5_5A5A,1'b1,"core_wr"};
        vecs[2] = '{1'b1,1'b0,4'h3,8'hFF,32'h0,        1'b0,1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b1,4'hF,8'hFF,32'h0,        1'b1,"core_rd"};
        vecs[3] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b1,1'b1,4'h8,32'h3000_03FC,32'h1122_3344,1'b0,1'b0,4'h8,8'hFF,32'h1122_3344,1'b0,"wb_wr_top"};
        vecs[4] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b1,1'b0,4'h1,32'h3000_0000,32'h0,        1'b0,1'b1,4'hF,8'h00,32'h0,        1'b0,"wb_rd_base"};
        vecs[5] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b1,1'b1,4'hF,32'h3000_0400,32'hDEAD_BEEF,1'b1,1'b1,4'h0,8'h00,32'h0,        1'b0,"wb_above"};
        vecs[6] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b1,1'b1,4'hF,32'h2FFF_FFFC,32'hDEAD_BEEF,1'b1,1'b1,4'h0,8'h00,32'h0,        1'b0,"wb_below"};
        vecs[7] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b1,1'b0,1'b1,4'hF,32'h3000_0008,32'h1,        1'b1,1'b1,4'h0,8'h00,32'h0,        1'b0,"wb_no_stb"};
        vecs[8] = '{1'b0,1'b0,4'h0,8'h00,32'h0,        1'b0,1'b1,1'b1,4'hF,32'h3000_0008,32'h1,        1'b1,1'b1,4'h0,8'h00,32'h0,        1'b0,"wb_no_cyc"};
        vecs[9] = '{1'b1,1'b1,4'hC,8'h03,32'h7700_0000,1'b1,1'b1,1'b1,4'hF,32'h3000_0020,32'h99,       1'b0,1'b0,4'hC,8'h03,32'h7700_0000,1'b1,"collide"};

        // Reset: outputs idle even with a core request pending.
        clearInputs();
        rstn = 1'b0;
        coreReq = 1'b1; coreWe = 1'b1; coreAddr = 8'h05; coreWdata = 32'h1234; coreBe = 4'hF;
        @(negedge clk);
        checkOutput("rst_csb", 32'(csb), 32'h1);
        checkOutput("rst_web", 32'(web), 32'h1);
        checkOutput("rst_wmask", 32'(wmask), 32'h0);
        checkOutput("rst_addr", 32'(sramAddr), 32'h0);
        checkOutput("rst_din", din, 32'h0);
        checkOutput("rst_gnt", 32'(coreGnt), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_rvalid", 32'(coreRvalid), 32'h0);
        clearInputs();
        @(negedge clk);
        rstn = 1'b1;

        // Wishbone write of 0xD to word 4, ack on the following cycle.
        driveSlot();
        cyc = 1'b1; stb = 1'b1; wbWe = 1'b1; sel = 4'hF; adr = 32'h3000_0010; datIn = 32'hD;
        @(negedge clk);
        checkOutput("wbwr_csb", 32'(csb), 32'h0);
        checkOutput("wbwr_web", 32'(web), 32'h0);
        checkOutput("wbwr_addr", 32'(sramAddr), 32'h4);
        checkOutput("wbwr_din", din, 32'hD);
        checkOutput("wbwr_ack0", 32'(ack), 32'h0);
        driveSlot();
        clearInputs();
        @(negedge clk);
        checkOutput("wbwr_ack1", 32'(ack), 32'h1);
        checkOutput("wbwr_csb1", 32'(csb), 32'h1);
        @(negedge clk);
        checkOutput("wbwr_ack2", 32'(ack), 32'h0);

        // Wishbone read back of word 4.
        driveSlot();
        cyc = 1'b1; stb = 1'b1; wbWe = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
        @(negedge clk);
        checkOutput("wbrd_web", 32'(web), 32'h1);
        checkOutput("wbrd_wmask", 32'(wmask), 32'hF);
        driveSlot();
        @(negedge clk);
        checkOutput("wbrd_ack", 32'(ack), 32'h1);
        checkOutput("wbrd_dat", datOut, 32'hD);
        checkOutput("wbrd_csb_resp", 32'(csb), 32'h1);
        driveSlot();
        clearInputs();

        // Core byte write to word 7, then read back.
        driveSlot();
        coreReq = 1'b1; coreWe = 1'b1; coreBe = 4'b0010; coreAddr = 8'h07; coreWdata = 32'h0000_1A00;
        @(negedge clk);
        checkOutput("cbw_gnt", 32'(coreGnt), 32'h1);
        checkOutput("cbw_wmask", 32'(wmask), 32'h2);
        checkOutput("cbw_web", 32'(web), 32'h0);
        driveSlot();
        coreReq = 1'b1; coreWe = 1'b0; coreBe = 4'hF; coreAddr = 8'h07; coreWdata = 32'h0;
        @(negedge clk);
        checkOutput("cbw_no_rvalid", 32'(coreRvalid), 32'h0);
        driveSlot();
        clearInputs();
        @(negedge clk);
        checkOutput("cbr_rvalid", 32'(coreRvalid), 32'h1);
        checkOutput("cbr_byte1", 32'(coreRdata[15:8]), 32'h1A);
        checkOutput("cbr_rdata", coreRdata, 32'h0000_1A00);
        @(negedge clk);
        checkOutput("cbr_rvalid_once", 32'(coreRvalid), 32'h0);

        // Table of single-cycle grant patterns.
        for (int i = 0; i < 10; i++) begin
            driveSlot();
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput({vecs[i].name, "_csb"}, 32'(csb), 32'(vecs[i].expCsb));
            checkOutput({vecs[i].name, "_web"}, 32'(web), 32'(vecs[i].expWeb));
            checkOutput({vecs[i].name, "_wmask"}, 32'(wmask), 32'(vecs[i].expWmask));
            checkOutput({vecs[i].name, "_addr"}, 32'(sramAddr), 32'(vecs[i].expAddr));
            checkOutput({vecs[i].name, "_din"}, din, vecs[i].expDin);
            checkOutput({vecs[i].name, "_gnt"}, 32'(coreGnt), 32'(vecs[i].expGnt));
            driveSlot();
            clearInputs();
        end

        // Outside the window: never touches the SRAM, never acks.
        driveSlot();
        cyc = 1'b1; stb = 1'b1; wbWe = 1'b0; sel = 4'hF; adr = 32'h3100_0000;
        badCycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!csb || ack) badCycles++;
        end
        checkOutput("oow_bad_cycles", 32'(badCycles), 32'h0);
        driveSlot();
        clearInputs();

        // Collision sequence starting from a fresh last-grant.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        driveSlot();
        coreReq = 1'b1; coreWe = 1'b0; coreBe = 4'hF; coreAddr = 8'h04;
        cyc = 1'b1; stb = 1'b1; wbWe = 1'b1; sel = 4'hF; adr = 32'h3000_0020; datIn = 32'h55;
        @(negedge clk);
        checkOutput("col_a_gnt", 32'(coreGnt), 32'h1);
        checkOutput("col_a_addr", 32'(sramAddr), 32'h4);
        driveSlot();
        @(negedge clk);
        checkOutput("col_b_rvalid", 32'(coreRvalid), 32'h1);
        checkOutput("col_b_rdata", coreRdata, 32'hD);
`ifdef DMEM_ARB_RR_EN
        checkOutput("col_b_gnt", 32'(coreGnt), 32'h0);
        checkOutput("col_b_addr", 32'(sramAddr), 32'h8);
        checkOutput("col_b_web", 32'(web), 32'h0);
`else
        checkOutput("col_b_gnt", 32'(coreGnt), 32'h1);
        checkOutput("col_b_addr", 32'(sramAddr), 32'h4);
        checkOutput("col_b_web", 32'(web), 32'h1);
`endif
        driveSlot();
        @(negedge clk);
        checkOutput("col_c_gnt", 32'(coreGnt), 32'h1);
`ifdef DMEM_ARB_RR_EN
        checkOutput("col_c_ack", 32'(ack), 32'h1);
`else
        checkOutput("col_c_ack", 32'(ack), 32'h0);
`endif
        driveSlot();
`ifndef DMEM_ARB_RR_EN
        coreReq = 1'b0;
`endif
        @(negedge clk);
        checkOutput("col_d_gnt", 32'(coreGnt), 32'h0);
        checkOutput("col_d_csb", 32'(csb), 32'h0);
        checkOutput("col_d_addr", 32'(sramAddr), 32'h8);
        driveSlot();
        clearInputs();
        @(negedge clk);
        checkOutput("col_e_ack", 32'(ack), 32'h1);
        driveSlot();

        // Reset asserted while a Wishbone response is due.
        driveSlot();
        cyc = 1'b1; stb = 1'b1; wbWe = 1'b0; sel = 4'hF; adr = 32'h3000_0010;
        driveSlot();
        checkOutput("rresp_ack_pre", 32'(ack), 32'h1);
        rstn = 1'b0;
        clearInputs();
        #1;
        checkOutput("rresp_ack_now", 32'(ack), 32'h0);
        checkOutput("rresp_dat_now", datOut, 32'h0);
        checkOutput("rresp_csb_now", 32'(csb), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        badCycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack || coreRvalid) badCycles++;
        end
        checkOutput("rresp_no_late_ack", 32'(badCycles), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: SRAM word-address width (256 x 32-bit words).
REQ-002 Parameter WB_BASE, default 32'h3000_0000: Wishbone byte-address base of the DMEM window.
REQ-003 wb_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 wb_rstn_i  in  1  asynchronous, active-low reset.
REQ-005 core_req_i / core_we_i / core_be_i[3:0] / core_addr_i[ADDR_W-1:0] / core_wdata_i[31:0]  in  core data-port request.
REQ-006 core_gnt_o  out  1  request accepted this cycle; core_rvalid_o  out  1  and core_rdata_o  out  32  return read data.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each; wbs_sel_i  in  4; wbs_adr_i, wbs_dat_i  in  32  Wishbone classic slave inputs.
REQ-008 wbs_ack_o  out  1; wbs_dat_o  out  32  Wishbone slave response.
REQ-009 csb0_o, web0_o  out  1  SRAM chip/write enables, active-low; wmask0_o  out  4; addr0_o  out  ADDR_W; din0_o  out  32.
REQ-010 dout0_i  in  32  SRAM read data, valid on the cycle after the access.

Function
REQ-011 The WB request is eligible when cyc&stb, (wbs_adr_i & ~(4*2^ADDR_W-1)) == WB_BASE, and the FSM is in IDLE.
REQ-012 The core request is eligible whenever core_req_i=1, in either FSM state.
REQ-013 At most one SRAM access is issued per cycle: csb0_o=0 only in a cycle where exactly one requester is granted.
REQ-014 Grant drives the SRAM port combinationally: addr0 = granted address (WB uses adr[ADDR_W+1:2]), din0 = wdata, wmask0 = be/sel on writes and 4'hF on reads, web0_o = ~we.
REQ-015 core_gnt_o is asserted in the same cycle the core access is issued; core_rvalid_o=1 exactly one cycle after a granted read, with core_rdata_o=dout0_i; no rvalid is produced for writes.
REQ-016 FSM states: IDLE and WB_RESP. IDLE->WB_RESP on WB grant; WB_RESP->IDLE unconditionally after one cycle.
REQ-017 In WB_RESP: wbs_ack_o=1 for exactly one cycle, wbs_dat_o=dout0_i for reads; WB is not re-granted in this cycle, although a core request may be granted.
REQ-018 WB access outside the window: no SRAM access and no ack; the request is left for other slaves.
REQ-019 Deassertion of cyc/stb in WB_RESP does not suppress the ack (classic single-cycle termination).
REQ-020 Idle outputs: csb0_o=1, web0_o=1, wmask0_o=0, addr0_o=0, din0_o=0.

Reset
REQ-021 Asserting wb_rstn_i=0 at any time forces IDLE, wbs_ack_o=0, core_rvalid_o=0, last-grant=WB, and the idle SRAM outputs, within the same cycle.
REQ-022 An access in flight at reset is dropped: no ack and no rvalid are emitted after release.

Configuration
REQ-023 With DMEM_ARB_RR_EN defined, simultaneous eligible requests are granted round-robin: the requester not granted last wins, and last-grant updates on every grant.
REQ-024 Without DMEM_ARB_RR_EN, the core has fixed priority and the last-grant register is not built.

Structure
REQ-025 Package dmem_arb_pkg holds the state enum (IDLE, WB_RESP), the requester ID constants (REQ_CORE, REQ_WB) and the default WB_BASE.
REQ-026 One sub-module, dmem_rr_arb, implements the 2-way grant logic, including the last-grant register and the macro selection; the FSM and muxing stay in dmem_arbiter.

Verification
REQ-027 WB write to 0x3000_0010, data 0xD, sel 4'hF -> cycle 0: csb0=0, web0=0, addr0=4, din0=0xD; cycle 1: ack=1.
REQ-028 WB read from 0x3000_0010 after the write -> ack one cycle after access, with wbs_dat_o=0xD.
REQ-029 Core read at addr 4 and WB write, both requested in the same cycle, with RR enabled and last-grant=WB -> core granted first; WB granted in the following cycle; next collision grants WB.
REQ-030 Core byte write, be=4'b0010, data 0x1A00 -> wmask0=4'b0010, no rvalid; a subsequent read returns byte1=0x1A.
REQ-031 WB access to 0x3100_0000 -> csb0 stays 1, no ack for 100 cycles.
REQ-032 Reset asserted in a WB_RESP cycle -> ack=0 immediately, FSM=IDLE, no ack after release.
